// File: rtl/comm_pkg.sv
// Shared constants and types for the commutation monitor: gate bit indices,
// full-on patterns, phase encoding, fault codes and monitor states.
package comm_pkg;

  localparam int A_P = 5;
  localparam int A_N = 4;
  localparam int B_P = 3;
  localparam int B_N = 2;
  localparam int C_P = 1;
  localparam int C_N = 0;

  localparam logic [5:0] PH_A   = 6'b110000;
  localparam logic [5:0] PH_B   = 6'b001100;
  localparam logic [5:0] PH_C   = 6'b000011;
  localparam logic [5:0] N_MASK = 6'b010101;
  localparam logic [5:0] P_MASK = 6'b101010;

  typedef enum logic [1:0] {
    PHASE_NONE = 2'b00,
    PHASE_A    = 2'b01,
    PHASE_B    = 2'b10,
    PHASE_C    = 2'b11
  } phase_e;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    ILLEGAL = 3'd1,
    MULTI   = 3'd2,
    DWELL   = 3'd3,
    OPEN    = 3'd4
  } fault_e;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  function automatic logic is_full_on(input logic [5:0] v);
    return (v == PH_A) || (v == PH_B) || (v == PH_C);
  endfunction

endpackage

// File: rtl/commutation_monitor_gate_pattern_check.sv
// Combinational classifier for one gate sample and the step from the previous
// sample: pattern legality, full-on phase decode and step exception flags.
module gate_pattern_check
  import comm_pkg::*;
(
  input  logic [5:0] prev,
  input  logic [5:0] gate,
  output logic       legal,
  output logic [1:0] phase,
  output logic       prev_inter,
  output logic       changed,
  output logic       hamming_gt1,
  output logic       startup_ok,
  output logic       open_step
);

  logic [2:0] gate_cnt;
  logic [2:0] prev_cnt;
  logic       gate_full;

  always_comb begin
    gate_cnt    = popcount6(gate);
    prev_cnt    = popcount6(prev);
    gate_full   = is_full_on(gate);
    // Two gates are only safe as one full phase or two same-rail gates.
    legal       = (gate_cnt == 3'd0) || (gate_cnt == 3'd1) ||
                  ((gate_cnt == 3'd2) && (gate_full ||
                                          ((gate & N_MASK) == 6'b000000) ||
                                          ((gate & P_MASK) == 6'b000000)));
    prev_inter  = (prev != 6'b000000) && !is_full_on(prev);
    changed     = (prev != gate);
    hamming_gt1 = (popcount6(prev ^ gate) > 3'd1);
    startup_ok  = (prev == 6'b000000) && gate_full;
    open_step   = (gate == 6'b000000) && (prev_cnt == 3'd2);
    case (gate)
      PH_A:    phase = PHASE_A;
      PH_B:    phase = PHASE_B;
      PH_C:    phase = PHASE_C;
      default: phase = PHASE_NONE;
    endcase
  end

endmodule

// File: rtl/commutation_monitor.sv
// Safety monitor on the 6-bit commutation gate bus: latches a sticky short
// fault with cause code. `define COMM_MON_STATS_EN adds the comm_count output.
module commutation_monitor
  import comm_pkg::*;
#(
  parameter int DWELL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [5:0]       gate,
  input  logic             fault_clr,
  output logic             short,
  output logic [2:0]       fault_code,
  output logic [1:0]       cur_phase
`ifdef COMM_MON_STATS_EN
  ,
  output logic [CNT_W-1:0] comm_count
`endif
);

  localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state;
  state_e           state_next;
  logic             short_next;
  logic [2:0]       code_next;
  fault_e           code;
  logic [5:0]       prev;
  logic [CNT_W-1:0] dwell_cnt;
  logic             prev_en;

  logic       legal;
  logic [1:0] phase;
  logic       prev_inter;
  logic       changed;
  logic       hamming_gt1;
  logic       startup_ok;
  logic       open_step;

  gate_pattern_check u_check (
    .prev        (prev),
    .gate        (gate),
    .legal       (legal),
    .phase       (phase),
    .prev_inter  (prev_inter),
    .changed     (changed),
    .hamming_gt1 (hamming_gt1),
    .startup_ok  (startup_ok),
    .open_step   (open_step)
  );

  // Step checks only trust history recorded while monitoring was enabled.
  always_comb begin
    code = NONE;
    if (!legal) begin
      code = ILLEGAL;
    end else if (prev_en && changed) begin
      if (open_step) begin
        code = OPEN;
      end else if (hamming_gt1 && !startup_ok) begin
        code = MULTI;
      end else if (prev_inter && (dwell_cnt < DWELL_LIM)) begin
        code = DWELL;
      end else begin
        code = NONE;
      end
    end else begin
      code = NONE;
    end
  end

  always_comb begin
    state_next = state;
    short_next = short;
    code_next  = fault_code;
    case (state)
      RUN: begin
        if (enable && (code != NONE)) begin
          state_next = FAULT;
          short_next = 1'b1;
          code_next  = code;
        end else begin
          state_next = RUN;
        end
      end
      FAULT: begin
        if (fault_clr && (gate == 6'b000000)) begin
          state_next = RUN;
          short_next = 1'b0;
          code_next  = NONE;
        end else begin
          state_next = FAULT;
        end
      end
      default: begin
        state_next = RUN;
        short_next = 1'b0;
        code_next  = NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      short      <= 1'b0;
      fault_code <= 3'd0;
      cur_phase  <= 2'b00;
      prev       <= 6'b000000;
      dwell_cnt  <= '0;
      prev_en    <= 1'b1;
    end else begin
      state      <= state_next;
      short      <= short_next;
      fault_code <= code_next;
      cur_phase  <= phase;
      prev       <= gate;
      prev_en    <= enable;
      if (changed) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt != CNT_MAX) begin
        dwell_cnt <= dwell_cnt + CNT_ONE;
      end
    end
  end

`ifdef COMM_MON_STATS_EN
  logic [1:0] last_ph;

  // Counts phase-to-phase transfers; any fault forgets the starting phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ph    <= 2'b00;
      comm_count <= '0;
    end else if ((state == FAULT) || (code != NONE)) begin
      last_ph <= 2'b00;
    end else if (phase != PHASE_NONE) begin
      last_ph <= phase;
      if ((last_ph != 2'b00) && (phase != last_ph) && (comm_count != CNT_MAX)) begin
        comm_count <= comm_count + CNT_ONE;
      end
    end
  end
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_commutation_monitor.sv
// Directed table-driven bench for commutation_monitor (DWELL_CYC=1) plus
// hand-written dwell sequences on a second instance with DWELL_CYC=3.
module tb_commutation_monitor;

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [5:0]  gate;
    logic        exp_short;
    logic [2:0]  exp_code;
    logic [1:0]  exp_ph;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 34;

  logic        clk;
  logic        rst, enable, fault_clr;
  logic [5:0]  gate;
  logic        short;
  logic [2:0]  fault_code;
  logic [1:0]  cur_phase;
  logic        rst3, enable3, fault_clr3;
  logic [5:0]  gate3;
  logic        short3;
  logic [2:0]  fault_code3;
  logic [1:0]  cur_phase3;
`ifdef COMM_MON_STATS_EN
  logic [15:0] comm_count, comm_count3;
`endif

  int   n_vec;
  int   n_err;
  vec_t vecs [NV];

  commutation_monitor #(.DWELL_CYC(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gate(gate), .fault_clr(fault_clr),
    .short(short), .fault_code(fault_code), .cur_phase(cur_phase)
`ifdef COMM_MON_STATS_EN
    , .comm_count(comm_count)
`endif
  );

  commutation_monitor #(.DWELL_CYC(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst3), .enable(enable3), .gate(gate3), .fault_clr(fault_clr3),
    .short(short3), .fault_code(fault_code3), .cur_phase(cur_phase3)
`ifdef COMM_MON_STATS_EN
    , .comm_count(comm_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input logic [5:0] g, input logic s,
                              input logic [2:0] fc, input logic [1:0] ph,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.gate = g;
    v.exp_short = s; v.exp_code = fc; v.exp_ph = ph; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic step3(input logic [5:0] g);
    gate3 = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input logic s, input logic [2:0] fc);
    n_vec++;
    if (short3 !== s || fault_code3 !== fc) begin
      n_err++;
      $display("FAIL %s: short=%b code=%0d, expected short=%b code=%0d",
               name, short3, fault_code3, s, fc);
    end
  endtask

  initial begin
    logic ok;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; enable = 1'b1; fault_clr = 1'b0; gate = 6'b000000;
    rst3 = 1'b1; enable3 = 1'b1; fault_clr3 = 1'b0; gate3 = 6'b000000;

    //              rst   en    clr   gate       short code  ph     cnt
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 6'b110000, 1'b0, 3'd0, 2'b01, 16'd0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 6'b100000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 6'b101000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 6'b001000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 6'b001100, 1'b0, 3'd0, 2'b10, 16'd1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 6'b000100, 1'b0, 3'd0, 2'b00, 16'd1);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 6'b000101, 1'b0, 3'd0, 2'b00, 16'd1);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 6'b000001, 1'b0, 3'd0, 2'b00, 16'd1);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 6'b000011, 1'b0, 3'd0, 2'b11, 16'd2);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 6'b100100, 1'b1, 3'd1, 2'b00, 16'd2);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 6'b110000, 1'b1, 3'd1, 2'b01, 16'd2);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 6'b110000, 1'b1, 3'd1, 2'b01, 16'd2);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 6'b100000, 1'b1, 3'd1, 2'b00, 16'd2);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 6'b000000, 1'b1, 3'd1, 2'b00, 16'd2);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd2);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 6'b110000, 1'b0, 3'd0, 2'b01, 16'd2);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 6'b001100, 1'b1, 3'd2, 2'b10, 16'd2);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 6'b100000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 6'b101000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 6'b000000, 1'b1, 3'd4, 2'b00, 16'd0);
    vecs[22] = mk(1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 6'b100100, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[24] = mk(1'b0, 1'b1, 1'b0, 6'b110000, 1'b0, 3'd0, 2'b01, 16'd0);
    vecs[25] = mk(1'b0, 1'b1, 1'b1, 6'b110000, 1'b0, 3'd0, 2'b01, 16'd0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 6'b111111, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[27] = mk(1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[28] = mk(1'b0, 1'b1, 1'b0, 6'b010100, 1'b1, 3'd2, 2'b00, 16'd0);
    vecs[29] = mk(1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 3'd2, 2'b00, 16'd0);
    vecs[30] = mk(1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[31] = mk(1'b0, 1'b1, 1'b0, 6'b000010, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[32] = mk(1'b0, 1'b1, 1'b0, 6'b001010, 1'b0, 3'd0, 2'b00, 16'd0);
    vecs[33] = mk(1'b0, 1'b1, 1'b0, 6'b101010, 1'b1, 3'd1, 2'b00, 16'd0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; enable = vecs[i].en; fault_clr = vecs[i].clr; gate = vecs[i].gate;
      @(posedge clk);
      #1;
      n_vec++;
      ok = (short === vecs[i].exp_short) && (fault_code === vecs[i].exp_code) &&
           (cur_phase === vecs[i].exp_ph);
`ifdef COMM_MON_STATS_EN
      ok = ok && (comm_count === vecs[i].exp_cnt);
`endif
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: short=%b code=%0d phase=%b, expected short=%b code=%0d phase=%b",
                 i, short, fault_code, cur_phase,
                 vecs[i].exp_short, vecs[i].exp_code, vecs[i].exp_ph);
`ifdef COMM_MON_STATS_EN
        $display("  vec%0d comm_count=%0d expected %0d", i, comm_count, vecs[i].exp_cnt);
`endif
      end
    end

    // Dwell of 3 cycles: 100000 held only 2 cycles must trip.
    rst3 = 1'b1;
    step3(6'b000000);
    check3("dwell_reset", 1'b0, 3'd0);
    rst3 = 1'b0;
    step3(6'b110000);
    step3(6'b100000);
    step3(6'b100000);
    check3("dwell_hold2", 1'b0, 3'd0);
    step3(6'b101000);
    check3("dwell_short", 1'b1, 3'd3);
    step3(6'b101000);
    check3("dwell_sticky", 1'b1, 3'd3);

    // Same sequence held 3 cycles is clean.
    rst3 = 1'b1;
    step3(6'b000000);
    check3("dwell_rst_fault", 1'b0, 3'd0);
    rst3 = 1'b0;
    step3(6'b110000);
    step3(6'b100000);
    step3(6'b100000);
    step3(6'b100000);
    step3(6'b101000);
    check3("dwell_hold3", 1'b0, 3'd0);
    step3(6'b101000);
    check3("dwell_stable", 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commutation_monitor.md
Name: commutation_monitor

Overview:
- Independent safety checker on the 6-bit gate-drive bus of the matrix-converter commutation FSM, i.e. the receiving end of that FSM's gate outputs.
- Each cycle it classifies the sampled gate pattern and the step from the previous pattern.
- On any unsafe pattern or step it raises a sticky `short` fault and a fault code. `short` feeds back into the FSM's Short input, which forces all gates off.

Parameters:
- DWELL_CYC, 1: minimum cycles a partial-conduction (intermediate) pattern must be held before the next change; 1 disables the check.
- CNT_W, 16: width of the dwell counter and the optional statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  monitoring active; when 0, checks are suppressed but the previous pattern is still tracked.
- gate  in  6  sampled gate bus. Bit mapping: [5]=A_P, [4]=A_N, [3]=B_P, [2]=B_N, [1]=C_P, [0]=C_N.
- fault_clr  in  1  request to clear a latched fault.
- short  out  1  latched fault, drives FSM Short.
- fault_code  out  3  cause of the latched fault (codes below).
- cur_phase  out  2  fully-on phase: 01=A, 10=B, 11=C, 00=none.

Behaviour:
- Reset:
  - short=0, fault_code=0, cur_phase=00.
  - Previous-pattern register = 000000, dwell counter = 0, state = RUN.
- Legal patterns (16 total):
  - 000000.
  - Full-on, one phase only: 110000, 001100, 000011.
  - Any single gate.
  - Two P gates on different phases: 101000, 100010, 001010.
  - Two N gates on different phases: 010100, 010001, 000101.
  - Everything else is illegal: mixed P/N across phases, three or more gates, or full-on plus any other gate.
- Legal steps (prev -> gate, when different):
  - Hamming distance exactly 1.
  - 000000 -> full-on (start-up).
  - Any -> 000000 is legal only from a single-gate pattern or from 000000.
- Fault codes, one per sample, highest priority first:
  - 1 ILLEGAL_PATTERN.
  - 4 OPEN_CIRCUIT: a two-gate or full-on pattern steps directly to 000000.
  - 2 MULTI_STEP: Hamming distance >1 and not an allowed exception.
  - 3 DWELL: an intermediate pattern (not 000000, not full-on) changes after fewer than DWELL_CYC cycles held.
  - 0 none.
- Dwell counter: reset to 0 whenever the pattern changes; increments, saturating at all-ones, while the pattern is stable.
- FSM:
  - RUN: when enable=1 and the sample yields a nonzero code, go to FAULT on the next edge with short=1 and fault_code latched. Latency is 1 cycle from the offending sample to short=1.
  - FAULT: short and fault_code hold regardless of further input, including further faults. Exit to RUN when fault_clr=1 and gate==000000 in the same cycle; short=0 and fault_code=0 on the next edge. fault_clr with a nonzero gate is ignored.
  - fault_clr while in RUN has no effect.
- enable=0: no fault can be raised; the previous pattern and dwell counter keep updating, so re-enabling never trips on stale history. A latched fault is not cleared by enable=0.
- cur_phase: registered decode of the current gate pattern; updates in every state.
- rst mid-FAULT: returns to RUN and clears short on the same edge.

Optional Feature:
- Macro: COMM_MON_STATS_EN.
- Defined:
  - Adds output `comm_count [CNT_W-1:0]`. It increments when cur_phase changes from one nonzero phase to a different nonzero phase via only legal steps with no fault in between, i.e. a completed safe commutation.
  - It saturates at all-ones and is cleared by rst only.
- Undefined: port and logic are absent.

Decomposition:
- Package comm_pkg holds:
  - Gate bit index constants (A_P..C_N).
  - Full-on pattern constants (PH_A/PH_B/PH_C).
  - Fault code enum (NONE=0, ILLEGAL=1, MULTI=2, DWELL=3, OPEN=4).
  - Phase encoding shared with the FSM's load codes (01/10/11).
- Sub-module gate_pattern_check: purely combinational. Takes prev and gate; outputs legal, full_on phase, intermediate flag, hamming_gt1 and the step-exception flags. The top level holds the registers, dwell counter and fault FSM.

Test Plan:
- Legal A->B commutation, positive current: 110000,100000,101000,001000,001100, one cycle each with DWELL_CYC=1 -> short stays 0; cur_phase 01->00->10. With COMM_MON_STATS_EN, comm_count=1.
- Gate 100100 for one cycle -> short=1 next cycle, fault_code=1. Later clean patterns keep short=1 until fault_clr=1 with gate=000000; short=0 on the following cycle.
- Step 110000 -> 001100 -> fault_code=2. Step 101000 -> 000000 -> fault_code=4.
- DWELL_CYC=3, 100000 held 2 cycles then 101000 -> fault_code=3. The same sequence holding 100000 for 3 cycles -> no fault.
- enable=0 while gate=100100, then enable=1 with gate=110000 -> no fault. fault_clr asserted with gate=110000 during FAULT -> short remains 1.
- rst asserted while in FAULT -> short=0, fault_code=0, cur_phase=00 on the next edge.
